// File: rtl/fpga_host_nbf_sipo_pkg.sv
// Shared types for the UART-to-NBF serial-in/parallel-out assembler.
package fpga_host_nbf_sipo_pkg;

  localparam int unsigned NBF_OPCODE_W = 8;
  localparam int unsigned NBF_ADDR_W   = 40;
  localparam int unsigned NBF_DATA_W   = 64;
  localparam int unsigned NBF_W        = NBF_OPCODE_W + NBF_ADDR_W + NBF_DATA_W;

  // Host NBF packet at the default field widths; opcode occupies the low byte.
  typedef struct packed {
    logic [NBF_DATA_W-1:0]   data;
    logic [NBF_ADDR_W-1:0]   addr;
    logic [NBF_OPCODE_W-1:0] opcode;
  } bp_fpga_host_nbf_s;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_fill = 2'd1,
    e_full = 2'd2
  } sipo_state_e;

endpackage

// File: rtl/fpga_host_nbf_sipo.sv
// Assembles LSB-first UART bytes into whole NBF packets; stalled or corrupted
// partial packets are discarded so the stream resynchronises on a packet boundary.
module fpga_host_nbf_sipo
  import fpga_host_nbf_sipo_pkg::*;
#(
  parameter int unsigned nbf_addr_width_p = 40,
  parameter int unsigned nbf_data_width_p = 64,
  parameter int unsigned uart_data_bits_p = 8,
  parameter int unsigned timeout_clks_p   = 262144
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic                                          rx_v_i,
  input  logic [uart_data_bits_p-1:0]                   rx_i,
  input  logic                                          rx_error_i,
  output logic                                          nbf_v_o,
  output logic [8+nbf_addr_width_p+nbf_data_width_p-1:0] nbf_o,
  input  logic                                          nbf_ready_and_i,
  output logic                                          error_o
);

  localparam int unsigned NbfWidth = 8 + nbf_addr_width_p + nbf_data_width_p;
  localparam int unsigned NbfBytes = NbfWidth / uart_data_bits_p;
  localparam int unsigned CntW     = (NbfBytes > 1) ? $clog2(NbfBytes) : 1;
  localparam int unsigned TmrW     = (timeout_clks_p > 1) ? $clog2(timeout_clks_p) : 1;
  localparam int unsigned Ub       = uart_data_bits_p;

  localparam logic [CntW-1:0] LastLane = CntW'(NbfBytes - 1);
  localparam logic [TmrW-1:0] TmrLimit = TmrW'(timeout_clks_p - 1);

  sipo_state_e          state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [TmrW-1:0]      tmr_q, tmr_d;
  logic [NbfWidth-1:0]  pkt_q, pkt_d;
  logic                 v_q, v_d;
  logic                 err_q, err_d;
  logic                 lane_we;
  logic [CntW-1:0]      lane_sel;

  // State register and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      count_q <= '0;
      tmr_q   <= '0;
      pkt_q   <= '0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tmr_q   <= tmr_d;
      pkt_q   <= pkt_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

  // Next-state, lane select, idle timer and error pulse.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tmr_d    = tmr_q;
    err_d    = 1'b0;
    lane_we  = 1'b0;
    lane_sel = count_q;

    unique case (state_q)
      e_idle: begin
        count_d = '0;
        tmr_d   = '0;
        if (rx_error_i) begin
          err_d = 1'b1;
        end else if (rx_v_i) begin
          lane_we  = 1'b1;
          lane_sel = '0;
          count_d  = CntW'(1);
          state_d  = e_fill;
        end
      end

      e_fill: begin
        if (rx_error_i) begin
          err_d   = 1'b1;
          count_d = '0;
          tmr_d   = '0;
          state_d = e_idle;
        end else if (rx_v_i) begin
          lane_we = 1'b1;
          tmr_d   = '0;
          if (count_q == LastLane) begin
            count_d = '0;
            state_d = e_full;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end else if (tmr_q == TmrLimit) begin
          // Sender went quiet mid-packet: drop the partial packet.
          err_d   = 1'b1;
          count_d = '0;
          tmr_d   = '0;
          state_d = e_idle;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end

      e_full: begin
        tmr_d   = '0;
        count_d = '0;
        if (nbf_ready_and_i) begin
          state_d = e_idle;
          if (rx_error_i) begin
            err_d = 1'b1;
          end else if (rx_v_i) begin
            // Byte arriving on the transfer edge starts the next packet.
            lane_we  = 1'b1;
            lane_sel = '0;
            count_d  = CntW'(1);
            state_d  = e_fill;
          end
        end else if (rx_v_i || rx_error_i) begin
          err_d = 1'b1;
        end
      end

      default: begin
        count_d = '0;
        tmr_d   = '0;
        state_d = e_idle;
      end
    endcase

    v_d = (state_d == e_full);
  end

  // Byte-lane write into the packet register; unwritten lanes keep stale data.
  always_comb begin
    pkt_d = pkt_q;
    for (int unsigned i = 0; i < NbfBytes; i++) begin
      if (lane_we && (lane_sel == CntW'(i))) begin
        pkt_d[i*Ub +: Ub] = rx_i;
      end
    end
  end

  assign nbf_v_o = v_q;
  assign nbf_o   = pkt_q;
  assign error_o = err_q;

endmodule

// File: tb/tb_fpga_host_nbf_sipo.sv
// Directed scoreboard bench for the UART-to-NBF assembler.
module tb_fpga_host_nbf_sipo;
  import fpga_host_nbf_sipo_pkg::*;

  localparam int unsigned Tmo  = 40;
  localparam int unsigned NW   = 112;
  localparam int unsigned NB   = 14;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          rx_v_i;
  logic [7:0]    rx_i;
  logic          rx_error_i;
  logic          nbf_v_o;
  logic [NW-1:0] nbf_o;
  logic          nbf_ready_and_i;
  logic          error_o;

  fpga_host_nbf_sipo #(
    .nbf_addr_width_p(40),
    .nbf_data_width_p(64),
    .uart_data_bits_p(8),
    .timeout_clks_p  (Tmo)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .rx_v_i         (rx_v_i),
    .rx_i           (rx_i),
    .rx_error_i     (rx_error_i),
    .nbf_v_o        (nbf_v_o),
    .nbf_o          (nbf_o),
    .nbf_ready_and_i(nbf_ready_and_i),
    .error_o        (error_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned err_cnt = 0;
  int unsigned pkt_cnt = 0;
  int unsigned vcyc_cnt = 0;
  logic [NW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [NW-1:0] build(input logic [7:0] base);
    logic [NW-1:0] p;
    p = '0;
    for (int i = 0; i < NB; i++) p[i*8 +: 8] = 8'(base + 8'(i));
    return p;
  endfunction

  task automatic send(input logic [7:0] b);
    rx_v_i = 1'b1;
    rx_i   = b;
    @(posedge clk_i); #1;
    rx_v_i = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send(8'(base + 8'(i)));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // Output monitor: pops the scoreboard on every accepted packet.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (error_o) err_cnt++;
      if (nbf_v_o) vcyc_cnt++;
      if (nbf_v_o && nbf_ready_and_i) begin
        pkt_cnt++;
        if (exp_q.size() == 0) chk("unexpected_pkt", 128'(nbf_o), 128'(0));
        else chk("pkt_data", 128'(nbf_o), 128'(exp_q.pop_front()));
      end
    end
  end

  int unsigned e0, p0, v0;
  bp_fpga_host_nbf_s pk;

  initial begin
    reset_i = 1'b1; rx_v_i = 1'b0; rx_i = '0; rx_error_i = 1'b0; nbf_ready_and_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_v", 128'(nbf_v_o), 128'(0));
    chk("rst_err", 128'(error_o), 128'(0));
    chk("rst_nbf", 128'(nbf_o), 128'(0));
    @(posedge clk_i); #1 reset_i = 1'b0;
    idle(1);

    // Single packet 0x01..0x0E with ready held high.
    e0 = err_cnt; p0 = pkt_cnt; v0 = vcyc_cnt;
    exp_q.push_back(build(8'h01));
    send_pkt(8'h01, NB);
    @(negedge clk_i);
    pk = bp_fpga_host_nbf_s'(nbf_o);
    chk("s1_v", 128'(nbf_v_o), 128'(1));
    chk("s1_opcode", 128'(pk.opcode), 128'(8'h01));
    chk("s1_addr", 128'(pk.addr), 128'(40'h0605040302));
    chk("s1_data", 128'(pk.data), 128'(64'h0E0D0C0B0A090807));
    idle(3);
    chk("s1_pkts", 128'(pkt_cnt - p0), 128'(1));
    chk("s1_vcyc", 128'(vcyc_cnt - v0), 128'(1));
    chk("s1_err", 128'(err_cnt - e0), 128'(0));

    // Back-to-back packets with downstream stalled: first byte of second dropped.
    e0 = err_cnt; p0 = pkt_cnt;
    nbf_ready_and_i = 1'b0;
    exp_q.push_back(build(8'h11));
    send_pkt(8'h11, NB);
    send(8'h21);
    idle(1);
    chk("s2_drop_err", 128'(err_cnt - e0), 128'(1));
    chk("s2_held_v", 128'(nbf_v_o), 128'(1));
    chk("s2_held_pkt", 128'(nbf_o), 128'(build(8'h11)));
    nbf_ready_and_i = 1'b1;
    exp_q.push_back(build(8'h22));
    send_pkt(8'h22, NB);
    idle(3);
    chk("s2_pkts", 128'(pkt_cnt - p0), 128'(2));
    chk("s2_err", 128'(err_cnt - e0), 128'(1));

    // Partial packet then silence: abort on timeout, not before.
    e0 = err_cnt; p0 = pkt_cnt;
    send_pkt(8'h51, 5);
    idle(Tmo - 3);
    chk("s3_no_early_abort", 128'(err_cnt - e0), 128'(0));
    idle(8);
    chk("s3_timeout_err", 128'(err_cnt - e0), 128'(1));
    exp_q.push_back(build(8'h01));
    send_pkt(8'h01, NB);
    idle(3);
    chk("s3_pkts", 128'(pkt_cnt - p0), 128'(1));
    chk("s3_err", 128'(err_cnt - e0), 128'(1));

    // Framing error with a byte mid-packet.
    e0 = err_cnt; p0 = pkt_cnt;
    send_pkt(8'h71, 7);
    rx_error_i = 1'b1;
    send(8'h78);
    rx_error_i = 1'b0;
    idle(2);
    chk("s4_err", 128'(err_cnt - e0), 128'(1));
    chk("s4_v", 128'(nbf_v_o), 128'(0));
    exp_q.push_back(build(8'h31));
    send_pkt(8'h31, NB);
    idle(3);
    chk("s4_pkts", 128'(pkt_cnt - p0), 128'(1));

    // Reset mid-packet.
    send_pkt(8'h81, 13);
    reset_i = 1'b1;
    #1;
    chk("s5_rst_v", 128'(nbf_v_o), 128'(0));
    chk("s5_rst_err", 128'(error_o), 128'(0));
    @(negedge clk_i);
    chk("s5_rst_v2", 128'(nbf_v_o), 128'(0));
    chk("s5_rst_err2", 128'(error_o), 128'(0));
    @(posedge clk_i); #1 reset_i = 1'b0;
    e0 = err_cnt; p0 = pkt_cnt;
    exp_q.push_back(build(8'h41));
    send_pkt(8'h41, NB);
    idle(3);
    chk("s5_pkts", 128'(pkt_cnt - p0), 128'(1));
    chk("s5_err", 128'(err_cnt - e0), 128'(0));

    // Ready asserted together with the next packet's first byte.
    e0 = err_cnt; p0 = pkt_cnt;
    nbf_ready_and_i = 1'b0;
    exp_q.push_back(build(8'h61));
    exp_q.push_back(build(8'hAA));
    send_pkt(8'h61, NB);
    idle(3);
    chk("s6_held_v", 128'(nbf_v_o), 128'(1));
    chk("s6_held_pkt", 128'(nbf_o), 128'(build(8'h61)));
    nbf_ready_and_i = 1'b1;
    send_pkt(8'hAA, NB);
    @(negedge clk_i);
    pk = bp_fpga_host_nbf_s'(nbf_o);
    chk("s6_opcode", 128'(pk.opcode), 128'(8'hAA));
    idle(3);
    chk("s6_pkts", 128'(pkt_cnt - p0), 128'(2));
    chk("s6_err", 128'(err_cnt - e0), 128'(0));

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
